// File: rtl/exe_muldiv_if.sv
// Handshake/bus bundle between the ID/EX register and the iterative
// multiply/divide unit in the execute stage.
interface exe_muldiv_if;
    logic        start;
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        ack;
    logic        flush;
    logic        exe_is_waiting;
    logic        done;
    logic [63:0] result;

    modport master (
        output start, op, a, b, ack, flush,
        input  exe_is_waiting, done, result
    );

    modport slave (
        input  start, op, a, b, ack, flush,
        output exe_is_waiting, done, result
    );
endinterface

// File: rtl/exe_muldiv.sv
// Iterative RV64M multiply/divide: shift-add multiply and restoring divide,
// one bit per cycle, with result held until the pipeline acknowledges it.
module exe_muldiv (
    input logic          clk,
    input logic          resetn,
    exe_muldiv_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [6:0]  count;
    logic        is_w, is_mul, is_rem, neg_q, neg_r;
    logic [63:0] acc;      // product accumulator or partial remainder
    logic [63:0] opx;      // multiplicand or divisor magnitude
    logic [63:0] q;        // multiplier or dividend/quotient shift register
    logic [63:0] result_q;

    // W results are always bit 31 of the 32-bit result, sign-extended.
    function automatic logic [63:0] fin(input logic w, input logic [63:0] x);
        return w ? {{32{x[31]}}, x[31:0]} : x;
    endfunction

    // ---------------- operand preparation (start cycle) ----------------
    logic        w_op, code_mul, legal, sgn, zext;
    logic [63:0] a_ext, b_ext, a_mag, b_mag, special_res;
    logic        a_neg, b_neg, div_zero, ovf, special, launch;

    assign w_op     = bus.op[3];
    assign code_mul = (bus.op[2:0] == 3'b000);
    assign legal    = code_mul || bus.op[2];
    assign sgn      = bus.op[2] && !bus.op[0];
    assign zext     = bus.op[2] && bus.op[0];

    assign a_ext = !w_op ? bus.a : zext ? {32'b0, bus.a[31:0]} : {{32{bus.a[31]}}, bus.a[31:0]};
    assign b_ext = !w_op ? bus.b : zext ? {32'b0, bus.b[31:0]} : {{32{bus.b[31]}}, bus.b[31:0]};
    assign a_neg = sgn && a_ext[63];
    assign b_neg = sgn && b_ext[63];
    assign a_mag = a_neg ? -a_ext : a_ext;
    assign b_mag = b_neg ? -b_ext : b_ext;

    assign div_zero = (b_ext == '0);
    assign ovf      = sgn && (b_ext == '1) &&
                      (a_ext == (w_op ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    assign special  = !legal || (!code_mul && (div_zero || ovf));
    assign launch   = bus.start && !bus.flush;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        special_res = '0;
        if (legal && div_zero)
            special_res = bus.op[1] ? a_ext : '1;
        else if (legal && ovf)
            special_res = bus.op[1] ? '0 : a_ext;
    end

    // ---------------- one iteration ----------------
    logic [64:0] trial;
    logic        q_bit;
    logic [63:0] div_acc_n, div_q_n, mul_acc_n, final_res;

    assign trial     = {acc, q[63]} - {1'b0, opx};
    assign q_bit     = !trial[64];
    assign div_acc_n = q_bit ? trial[63:0] : {acc[62:0], q[63]};
    assign div_q_n   = {q[62:0], q_bit};
    assign mul_acc_n = acc + (q[0] ? opx : 64'd0);

    always_comb begin
        final_res = '0;
        if (is_mul)
            final_res = mul_acc_n;
        else if (is_rem)
            final_res = neg_r ? -div_acc_n : div_acc_n;
        else
            final_res = neg_q ? -div_q_n : div_q_n;
    end

    // ---------------- sequential control ----------------
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            count    <= '0;
            is_w     <= 1'b0;
            is_mul   <= 1'b0;
            is_rem   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            acc      <= '0;
            opx      <= '0;
            q        <= '0;
            result_q <= '0;
        end else if (bus.flush) begin
            state <= IDLE;
            count <= '0;
        end else begin
            unique case (state)
                IDLE: if (launch) begin
                    is_w   <= w_op;
                    is_mul <= code_mul;
                    is_rem <= bus.op[1];
                    neg_q  <= a_neg ^ b_neg;
                    neg_r  <= a_neg;
                    acc    <= '0;
                    if (special) begin
                        result_q <= fin(w_op, special_res);
                        state    <= DONE;
                    end else begin
                        count <= w_op ? 7'd32 : 7'd64;
                        opx   <= code_mul ? a_ext : b_mag;
                        // Divide works MSB first, so a W dividend is left-aligned.
                        q     <= code_mul ? b_ext : (w_op ? {a_mag[31:0], 32'b0} : a_mag);
                        state <= RUN;
                    end
                end
                RUN: begin
                    count <= count - 7'd1;
                    if (is_mul) begin
                        acc <= mul_acc_n;
                        opx <= {opx[62:0], 1'b0};
                        q   <= {1'b0, q[63:1]};
                    end else begin
                        acc <= div_acc_n;
                        q   <= div_q_n;
                    end
                    if (count == 7'd1) begin
                        result_q <= fin(is_w, final_res);
                        state    <= DONE;
                    end
                end
                DONE: if (bus.ack) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.exe_is_waiting = resetn && !bus.flush &&
                                (((state == IDLE) && bus.start) || (state == RUN));
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;
endmodule

// File: tb/tb_exe_muldiv.sv
// Directed bench for exe_muldiv: expected results queued at launch and
// compared (value and latency) when done rises.
module tb_exe_muldiv;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    exe_muldiv_if bus ();
    exe_muldiv dut (.clk(clk), .resetn(resetn), .bus(bus));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       tag;
        logic [63:0] res;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int t0 = 0;

    localparam logic [3:0] MUL = 4'b0000, DIV = 4'b0100, DIVU = 4'b0101,
                           REM = 4'b0110, REMU = 4'b0111;
    localparam logic [3:0] MULW = 4'b1000, DIVW = 4'b1100, REMUW = 4'b1111;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic launch(input string tag, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] res, input int lat,
                          input logic ackv);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.ack   = ackv;
        sb.push_back('{tag, res, lat});
        t0 = cyc;
        #1 check({tag, "_wait_start"}, 64'(bus.exe_is_waiting), 64'd1);
    endtask

    task automatic wait_done();
        exp_t e;
        int   n = 0;
        logic wait_ok = 1'b1;
        @(negedge clk);
        while (!bus.done && n < 200) begin
            if (!bus.exe_is_waiting) wait_ok = 1'b0;
            n++;
            @(negedge clk);
        end
        e = sb.pop_front();
        if (e.lat > 1) check({e.tag, "_wait_run"}, 64'(wait_ok), 64'd1);
        check({e.tag, "_done"}, 64'(bus.done), 64'd1);
        check({e.tag, "_lat"}, 64'(cyc - t0), 64'(e.lat));
        check({e.tag, "_res"}, bus.result, e.res);
        check({e.tag, "_wait_done"}, 64'(bus.exe_is_waiting), 64'd0);
        if (bus.ack) bus.start = 1'b0;
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] res, input int lat);
        launch(tag, op, a, b, res, lat, 1'b1);
        wait_done();
    endtask

    logic [63:0] ra, rb, rexp;

    initial begin
        // Reset: start asserted but must be ignored.
        bus.start = 1'b1; bus.op = DIV; bus.a = 64'd9; bus.b = 64'd3;
        bus.ack = 1'b1; bus.flush = 1'b0;
        #2;
        check("rst_wait", 64'(bus.exe_is_waiting), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_result", bus.result, 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        resetn = 1'b1;

        run("divu", DIVU, 64'd100, 64'd7, 64'd14, 65);
        run("remu", REMU, 64'd100, 64'd7, 64'd2, 65);
        run("rem_neg", REM, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        run("div_neg", DIV, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        run("div_zero", DIV, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run("rem_zero", REM, 64'd5, 64'd0, 64'd5, 1);
        run("div_ovf", DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h8000_0000_0000_0000, 1);
        run("mulw", MULW, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);
        run("mul_neg", MUL, 64'd3, -64'sd4, 64'hFFFF_FFFF_FFFF_FFF4, 65);
        run("divw", DIVW, 64'h1234_5678_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 33);
        run("remuw_zero", REMUW, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_0000_0000,
            64'hFFFF_FFFF_8000_0000, 1);
        run("divw_ovf", DIVW, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'hFFFF_FFFF_8000_0000, 1);
        run("illegal", 4'b0011, 64'd77, 64'd5, 64'd0, 1);

        // Random operands against the language's own arithmetic.
        for (int i = 0; i < 3; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rexp = ra * rb;
            run("mul_rand", MUL, ra, rb, rexp, 65);
            rb = rb | 64'h1;
            rexp = ra / rb;
            run("divu_rand", DIVU, ra, rb, rexp, 65);
            rb = {1'b0, rb[62:0]};
            rexp = 64'($signed(ra) % $signed(rb));
            run("rem_rand", REM, ra, rb, rexp, 65);
        end

        // Hold ack low in DONE: result stable, no relaunch while start stays high.
        launch("hold", DIVU, 64'd1000, 64'd10, 64'd100, 65, 1'b0);
        wait_done();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_done", 64'(bus.done), 64'd1);
            check("hold_result", bus.result, 64'd100);
            check("hold_wait", 64'(bus.exe_is_waiting), 64'd0);
        end
        bus.ack = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        check("hold_idle_done", 64'(bus.done), 64'd0);

        // Flush at t+10 of a DIV.
        @(negedge clk);
        bus.start = 1'b1; bus.op = DIV; bus.a = 64'd1000; bus.b = 64'd3;
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        #1 check("flush_wait", 64'(bus.exe_is_waiting), 64'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.start = 1'b0;
        #1;
        check("flush_done", 64'(bus.done), 64'd0);
        check("flush_wait_idle", 64'(bus.exe_is_waiting), 64'd0);
        check("flush_result_kept", bus.result, 64'd100);
        repeat (3) @(negedge clk);
        check("flush_stays_idle", 64'(bus.done), 64'd0);

        // Reset at t+20 of another op, then a fresh op.
        @(negedge clk);
        bus.start = 1'b1; bus.op = DIVU; bus.a = 64'd999; bus.b = 64'd4;
        repeat (20) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("rst_mid_done", 64'(bus.done), 64'd0);
        check("rst_mid_result", bus.result, 64'd0);
        check("rst_mid_wait", 64'(bus.exe_is_waiting), 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        resetn = 1'b1;
        run("after_rst", DIVU, 64'd999, 64'd4, 64'd249, 65);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
